// File: rtl/s2_to_s8_fifo.sv
// Dibit-in, byte-out FIFO: 2-bit writes are packed little-dibit-first into bytes
// and presented through a registered output stage with valid/ready flow control.
module s2_to_s8_fifo #(
  parameter int DEPTH_BYTES = 64,
  localparam int DW = $clog2(DEPTH_BYTES * 4),
  localparam int BW = $clog2(DEPTH_BYTES)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          CLR,
  input  logic          WR_VALID,
  input  logic [1:0]    WR_DATA,
  output logic          WR_READY,
  output logic          RD_VALID,
  output logic [7:0]    RD_DATA,
  input  logic          RD_READY,
  output logic [DW:0]   FILL
);

  // Handshake: a beat transfers on a rising edge where valid and ready are both
  // high; valid never waits on ready, and WR_READY depends on registered state only.

  logic [7:0]  mem [DEPTH_BYTES];

  logic [DW:0] wr_ptr_q, wr_ptr_d;
  logic [BW:0] rd_ptr_q, rd_ptr_d;
  logic        rd_valid_q, rd_valid_d;
  logic [7:0]  rd_data_q, rd_data_d;

  logic [DW:0] fill;
  logic        wr_fire;
  logic        ld_fire;

  // Both pointers carry a wrap bit, so their difference (in dibits) is the
  // storage occupancy from 0 up to and including DEPTH_BYTES*4.
  assign fill     = wr_ptr_q - {rd_ptr_q, 2'b00};
  assign WR_READY = ~fill[DW];
  assign wr_fire  = WR_VALID & WR_READY;
  assign ld_fire  = (fill >= (DW+1)'(4)) & (~rd_valid_q | RD_READY);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    if (CLR) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      rd_valid_d = 1'b0;
      rd_data_d  = 8'h00;
    end else begin
      if (wr_fire) begin
        wr_ptr_d = wr_ptr_q + (DW+1)'(1);
      end
      if (ld_fire) begin
        rd_ptr_d   = rd_ptr_q + (BW+1)'(1);
        rd_valid_d = 1'b1;
        rd_data_d  = mem[rd_ptr_q[BW-1:0]];
      end else if (RD_READY) begin
        rd_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Storage is left unreset; a dibit lands in the byte lane picked by the
  // two low bits of the write pointer.
  always_ff @(posedge CLK) begin
    if (wr_fire && !CLR) begin
      mem[wr_ptr_q[DW-1:2]][{wr_ptr_q[1:0], 1'b0} +: 2] <= WR_DATA;
    end
  end

  assign RD_VALID = rd_valid_q;
  assign RD_DATA  = rd_data_q;
  assign FILL     = fill;

endmodule

// File: tb/tb_s2_to_s8_fifo.sv
// Directed bench for s2_to_s8_fifo: packing, backpressure, full, partial byte,
// simultaneous write/load, and reset/clear in mid-stream.
module tb_s2_to_s8_fifo;

  localparam int DEPTH_BYTES = 64;
  localparam int DW = $clog2(DEPTH_BYTES * 4);

  logic          clk;
  logic          rst_n;
  logic          clr;
  logic          wr_valid;
  logic [1:0]    wr_data;
  logic          wr_ready;
  logic          rd_valid;
  logic [7:0]    rd_data;
  logic          rd_ready;
  logic [DW:0]   fill;

  int n_checks;
  int n_pass;
  logic [7:0] exp_q[$];

  s2_to_s8_fifo #(.DEPTH_BYTES(DEPTH_BYTES)) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .CLR      (clr),
    .WR_VALID (wr_valid),
    .WR_DATA  (wr_data),
    .WR_READY (wr_ready),
    .RD_VALID (rd_valid),
    .RD_DATA  (rd_data),
    .RD_READY (rd_ready),
    .FILL     (fill)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  function automatic logic [1:0] pat(input int i);
    return 2'(i ^ (i >> 2) ^ (i >> 5));
  endfunction

  initial begin
    int acc;
    logic was_ready;
    logic [1:0] d;
    logic [7:0] asm_b;
    logic [7:0] e;

    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    clr      = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 2'b00;
    rd_ready = 1'b0;

    // reset state
    #23;
    check("rst_fill", 32'(fill), 0);
    check("rst_valid", 32'(rd_valid), 0);
    check("rst_data", 32'(rd_data), 0);
    check("rst_wr_ready", 32'(wr_ready), 1);
    rst_n = 1'b1;
    tick();

    // basic packing 0,1,2,3 -> 0xE4
    rd_ready = 1'b1;
    wr(2'd0); wr(2'd1); wr(2'd2); wr(2'd3);
    check("pack_fill4", 32'(fill), 4);
    check("pack_valid_early", 32'(rd_valid), 0);
    tick();
    check("pack_valid", 32'(rd_valid), 1);
    check("pack_data", 32'(rd_data), 32'hE4);
    check("pack_fill0", 32'(fill), 0);
    tick();
    check("pack_consumed", 32'(rd_valid), 0);

    // partial byte held back until completed
    rd_ready = 1'b0;
    wr(2'd1); wr(2'd2); wr(2'd3);
    repeat (20) tick();
    check("part_valid", 32'(rd_valid), 0);
    check("part_fill", 32'(fill), 3);
    wr(2'd0);
    tick();
    check("part_done_valid", 32'(rd_valid), 1);
    check("part_done_data", 32'(rd_data), 32'h39);
    rd_ready = 1'b1;
    tick();
    check("part_consumed", 32'(rd_valid), 0);

    // backpressure: 0x5A held while a second byte waits in storage
    rd_ready = 1'b0;
    wr(2'd2); wr(2'd2); wr(2'd1); wr(2'd1);
    tick();
    check("bp_valid", 32'(rd_valid), 1);
    wr(2'd3); wr(2'd0); wr(2'd3); wr(2'd0);
    check("bp_fill", 32'(fill), 4);
    for (int i = 0; i < 10; i++) begin
      check("bp_hold", {23'd0, rd_valid, rd_data}, {23'd0, 1'b1, 8'h5A});
      tick();
    end
    rd_ready = 1'b1;
    tick();
    check("bp_next", {23'd0, rd_valid, rd_data}, {23'd0, 1'b1, 8'h33});
    tick();
    check("bp_empty_valid", 32'(rd_valid), 0);
    check("bp_keep_data", 32'(rd_data), 32'h33);

    // simultaneous write and load at FILL=7
    rd_ready = 1'b0;
    wr(2'd0); wr(2'd1); wr(2'd2); wr(2'd3);
    wr(2'd3); wr(2'd2); wr(2'd1); wr(2'd0);
    wr(2'd1); wr(2'd1); wr(2'd1);
    check("sim_fill7", 32'(fill), 7);
    check("sim_head", 32'(rd_data), 32'hE4);
    rd_ready = 1'b1;
    wr(2'd1);
    check("sim_fill4", 32'(fill), 4);
    check("sim_data", 32'(rd_data), 32'h1B);
    tick();
    check("sim_data2", 32'(rd_data), 32'h55);
    check("sim_fill0", 32'(fill), 0);
    tick();
    check("sim_drained", 32'(rd_valid), 0);

    // fill to full with reads stalled, then drain back-to-back
    rd_ready = 1'b0;
    wr_valid = 1'b1;
    acc = 0;
    asm_b = 8'h00;
    for (int c = 0; c < 261; c++) begin
      d = pat(acc);
      wr_data = d;
      was_ready = wr_ready;
      tick();
      if (was_ready) begin
        asm_b[2*(acc%4) +: 2] = d;
        if (acc % 4 == 3) exp_q.push_back(asm_b);
        acc++;
        if (acc == 256) check("full_fill_256w", 32'(fill), 252);
      end
    end
    wr_valid = 1'b0;
    check("full_accepted", 32'(acc), 260);
    check("full_fill", 32'(fill), 256);
    check("full_wr_ready", 32'(wr_ready), 0);
    check("full_q_size", 32'(exp_q.size()), 65);
    rd_ready = 1'b1;
    for (int i = 0; i < 65; i++) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
      check("drain", {23'd0, rd_valid, rd_data}, {23'd0, 1'b1, e});
      tick();
    end
    check("drain_valid", 32'(rd_valid), 0);
    check("drain_fill", 32'(fill), 0);

    // asynchronous reset at FILL=130 with a byte held
    rd_ready = 1'b0;
    for (int i = 0; i < 134; i++) wr(pat(i));
    check("mid_fill", 32'(fill), 130);
    check("mid_valid", 32'(rd_valid), 1);
    rst_n = 1'b0;
    #2;
    check("arst_fill", 32'(fill), 0);
    check("arst_valid", 32'(rd_valid), 0);
    check("arst_data", 32'(rd_data), 0);
    check("arst_wr_ready", 32'(wr_ready), 1);
    rst_n = 1'b1;
    wr(2'd3); wr(2'd3); wr(2'd3); wr(2'd3);
    tick();
    check("arst_ff", {23'd0, rd_valid, rd_data}, {23'd0, 1'b1, 8'hFF});

    // synchronous clear wins over a write and a read on the same edge
    wr(2'd1); wr(2'd2); wr(2'd3); wr(2'd0); wr(2'd1);
    check("clr_pre_fill", 32'(fill), 5);
    clr      = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 2'd2;
    rd_ready = 1'b1;
    tick();
    clr      = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    check("clr_fill", 32'(fill), 0);
    check("clr_valid", 32'(rd_valid), 0);
    check("clr_data", 32'(rd_data), 0);
    check("clr_wr_ready", 32'(wr_ready), 1);
    wr(2'd3); wr(2'd3); wr(2'd3); wr(2'd3);
    tick();
    check("clr_ff", {23'd0, rd_valid, rd_data}, {23'd0, 1'b1, 8'hFF});

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
